// File: rtl/tsm_sysreg_arb_pkg.sv
// Shared constants, FSM encoding and init-table helpers for the TSE sysreg arbiter.
package tsm_sysreg_arb_pkg;

  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned INIT_ENTRY_W = 37;
  localparam int unsigned INIT_MAX     = 16;
  localparam int unsigned INIT_TABLE_W = INIT_ENTRY_W * INIT_MAX;
  localparam int unsigned IDX_W        = 5;

  // Implemented system registers (0x17 is a hole in the map)
  localparam logic [ADDR_W-1:0] REG_ADDR_10 = 5'h10;
  localparam logic [ADDR_W-1:0] REG_ADDR_11 = 5'h11;
  localparam logic [ADDR_W-1:0] REG_ADDR_12 = 5'h12;
  localparam logic [ADDR_W-1:0] REG_ADDR_13 = 5'h13;
  localparam logic [ADDR_W-1:0] REG_ADDR_14 = 5'h14;
  localparam logic [ADDR_W-1:0] REG_ADDR_15 = 5'h15;
  localparam logic [ADDR_W-1:0] REG_ADDR_16 = 5'h16;
  localparam logic [ADDR_W-1:0] REG_ADDR_18 = 5'h18;
  localparam logic [ADDR_W-1:0] REG_ADDR_19 = 5'h19;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  // One init-table entry, address in the upper bits
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } init_entry_t;

  // Pick entry idx out of the flat init table (entry 0 at the LSBs)
  function automatic init_entry_t table_entry(input logic [INIT_TABLE_W-1:0] tbl,
                                              input logic [IDX_W-1:0]        idx);
    return init_entry_t'(tbl[32'(idx[3:0]) * INIT_ENTRY_W +: INIT_ENTRY_W]);
  endfunction

  // Address decode of the register map
  function automatic logic reg_mapped(input logic [ADDR_W-1:0] addr);
    return addr inside {REG_ADDR_10, REG_ADDR_11, REG_ADDR_12, REG_ADDR_13, REG_ADDR_14,
                        REG_ADDR_15, REG_ADDR_16, REG_ADDR_18, REG_ADDR_19};
  endfunction

endpackage

// File: rtl/tsm_rr_arb2.sv
// Two-way grant (host vs internal) with a last-served pointer for round-robin.
module tsm_rr_arb2 #(
  parameter int unsigned RR_EN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hst_req,
  input  logic int_req,
  input  logic update,
  input  logic served_int,
  output logic gnt_any_c,
  output logic gnt_int_c
);

  logic last_int;

  // Last-served pointer; reset to internal so the host wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_int <= 1'b1;
    end else if (update) begin
      last_int <= served_int;
    end
  end

  // Grant decision for the current request pair
  always_comb begin
    gnt_any_c = hst_req | int_req;
    gnt_int_c = int_req;
    if (hst_req && int_req) begin
      gnt_int_c = (RR_EN != 0) ? !last_int : 1'b0;
    end
  end

endmodule

// File: rtl/tsm_sysreg_arb.sv
// Init-table sequencer and host/internal arbiter in front of the TSE sysreg bank.
module tsm_sysreg_arb
  import tsm_sysreg_arb_pkg::*;
#(
  parameter int unsigned              INIT_EN    = 1,
  parameter int unsigned              INIT_DEPTH = 4,
  parameter logic [INIT_TABLE_W-1:0]  INIT_TABLE = '0,
  parameter int unsigned              RR_EN      = 1
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hst_req,
  input  logic              hst_wr,
  input  logic [ADDR_W-1:0] hst_addr,
  input  logic [DATA_W-1:0] hst_wdata,
  output logic              hst_ack,
  output logic [DATA_W-1:0] hst_rdata,
  output logic              hst_err,
  input  logic              int_req,
  input  logic              int_wr,
  input  logic [ADDR_W-1:0] int_addr,
  input  logic [DATA_W-1:0] int_wdata,
  output logic              int_ack,
  output logic [DATA_W-1:0] int_rdata,
  output logic              int_err,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_cs_n,
  output logic              reg_wr_n,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_hit,
  output logic              init_done,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              gnt_int_q, gnt_int_d;
  logic              gnt_any_c, gnt_int_c;
  logic              arb_update;
  init_entry_t       entry;
  logic [DATA_W-1:0] rd_val;

  logic              hst_ack_d, int_ack_d, hst_err_d, int_err_d;
  logic [DATA_W-1:0] hst_rdata_d, int_rdata_d, reg_wdata_d;
  logic [ADDR_W-1:0] reg_addr_d;
  logic              reg_cs_n_d, reg_wr_n_d, init_done_d, busy_d;

  tsm_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk        (hclk),
    .rst_n      (hresetn),
    .hst_req    (hst_req),
    .int_req    (int_req),
    .update     (arb_update),
    .served_int (gnt_int_q),
    .gnt_any_c  (gnt_any_c),
    .gnt_int_c  (gnt_int_c)
  );

  // State, init index and all output registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= ST_INIT;
      idx_q     <= '0;
      gnt_int_q <= 1'b0;
      hst_ack   <= 1'b0;
      hst_rdata <= '0;
      hst_err   <= 1'b0;
      int_ack   <= 1'b0;
      int_rdata <= '0;
      int_err   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_cs_n  <= 1'b1;
      reg_wr_n  <= 1'b1;
      init_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gnt_int_q <= gnt_int_d;
      hst_ack   <= hst_ack_d;
      hst_rdata <= hst_rdata_d;
      hst_err   <= hst_err_d;
      int_ack   <= int_ack_d;
      int_rdata <= int_rdata_d;
      int_err   <= int_err_d;
      reg_addr  <= reg_addr_d;
      reg_wdata <= reg_wdata_d;
      reg_cs_n  <= reg_cs_n_d;
      reg_wr_n  <= reg_wr_n_d;
      init_done <= init_done_d;
      busy      <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gnt_int_d   = gnt_int_q;
    hst_ack_d   = 1'b0;
    int_ack_d   = 1'b0;
    hst_rdata_d = hst_rdata;
    hst_err_d   = hst_err;
    int_rdata_d = int_rdata;
    int_err_d   = int_err;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    reg_cs_n_d  = 1'b1;
    reg_wr_n_d  = 1'b1;
    init_done_d = init_done;
    arb_update  = 1'b0;
    entry       = table_entry(INIT_TABLE, idx_q);
    rd_val      = reg_hit ? reg_rdata : '0;

    case (state_q)
      ST_INIT: begin
        if (INIT_EN == 0 || idx_q == IDX_W'(INIT_DEPTH)) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          reg_addr_d  = entry.addr;
          reg_wdata_d = entry.data;
          reg_cs_n_d  = 1'b0;
          reg_wr_n_d  = 1'b0;
          idx_d       = idx_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (gnt_any_c) begin
          gnt_int_d   = gnt_int_c;
          reg_addr_d  = gnt_int_c ? int_addr  : hst_addr;
          reg_wdata_d = gnt_int_c ? int_wdata : hst_wdata;
          reg_cs_n_d  = 1'b0;
          reg_wr_n_d  = gnt_int_c ? !int_wr : !hst_wr;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Bank data is the pre-write value while the strobe is still active
        if (gnt_int_q) begin
          int_ack_d   = 1'b1;
          int_rdata_d = rd_val;
          int_err_d   = !reg_hit;
        end else begin
          hst_ack_d   = 1'b1;
          hst_rdata_d = rd_val;
          hst_err_d   = !reg_hit;
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        arb_update = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_tsm_sysreg_arb.sv
// Randomized self-checking bench for tsm_sysreg_arb against a transaction-level model.
`timescale 1ns/1ps
module tb_tsm_sysreg_arb;
  import tsm_sysreg_arb_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam logic [INIT_TABLE_W-1:0] TBL =
    INIT_TABLE_W'({5'h11, 32'h1234_5678, 5'h10, 32'h0000_002A});
  localparam logic [31:0] F_BANK_DATA = 32'hA5A5_0000;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hst_req, hst_wr, int_req, int_wr;
  logic [4:0]  hst_addr, int_addr;
  logic [31:0] hst_wdata, int_wdata;
  logic        hst_ack, hst_err, int_ack, int_err;
  logic [31:0] hst_rdata, int_rdata;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_cs_n, reg_wr_n, reg_hit, init_done, busy;

  logic        f_hst_req, f_int_req;
  logic [4:0]  f_hst_addr, f_int_addr;
  logic [31:0] f_hst_wdata, f_int_wdata;
  logic        f_hst_ack, f_hst_err, f_int_ack, f_int_err;
  logic [31:0] f_hst_rdata, f_int_rdata;
  logic [4:0]  f_reg_addr;
  logic [31:0] f_reg_wdata, f_reg_rdata;
  logic        f_reg_cs_n, f_reg_wr_n, f_reg_hit, f_init_done, f_busy;

  always #5 hclk = ~hclk;

  tsm_sysreg_arb #(.INIT_EN(1), .INIT_DEPTH(DEPTH), .INIT_TABLE(TBL), .RR_EN(1)) u_dut (
    .hclk(hclk), .hresetn(hresetn),
    .hst_req(hst_req), .hst_wr(hst_wr), .hst_addr(hst_addr), .hst_wdata(hst_wdata),
    .hst_ack(hst_ack), .hst_rdata(hst_rdata), .hst_err(hst_err),
    .int_req(int_req), .int_wr(int_wr), .int_addr(int_addr), .int_wdata(int_wdata),
    .int_ack(int_ack), .int_rdata(int_rdata), .int_err(int_err),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_cs_n(reg_cs_n), .reg_wr_n(reg_wr_n),
    .reg_rdata(reg_rdata), .reg_hit(reg_hit), .init_done(init_done), .busy(busy)
  );

  tsm_sysreg_arb #(.INIT_EN(0), .INIT_DEPTH(DEPTH), .INIT_TABLE(TBL), .RR_EN(0)) u_fix (
    .hclk(hclk), .hresetn(hresetn),
    .hst_req(f_hst_req), .hst_wr(1'b0), .hst_addr(f_hst_addr), .hst_wdata(f_hst_wdata),
    .hst_ack(f_hst_ack), .hst_rdata(f_hst_rdata), .hst_err(f_hst_err),
    .int_req(f_int_req), .int_wr(1'b0), .int_addr(f_int_addr), .int_wdata(f_int_wdata),
    .int_ack(f_int_ack), .int_rdata(f_int_rdata), .int_err(f_int_err),
    .reg_addr(f_reg_addr), .reg_wdata(f_reg_wdata), .reg_cs_n(f_reg_cs_n), .reg_wr_n(f_reg_wr_n),
    .reg_rdata(f_reg_rdata), .reg_hit(f_reg_hit), .init_done(f_init_done), .busy(f_busy)
  );

  // Register bank stand-in: combinational read, write on strobed edge
  bit [31:0] mem [32];
  assign reg_hit   = reg_mapped(reg_addr);
  assign reg_rdata = reg_hit ? mem[reg_addr] : 32'h0;
  always @(posedge hclk) begin
    if (!reg_cs_n && !reg_wr_n && reg_mapped(reg_addr)) mem[reg_addr] <= reg_wdata;
  end
  assign f_reg_rdata = F_BANK_DATA;
  assign f_reg_hit   = 1'b1;

  // Reference model state
  bit [31:0] ref_mem [32];
  bit        ref_last_int;
  logic [31:0] exp_h_rdata, exp_i_rdata;
  logic        exp_h_err, exp_i_err;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic bit tb_mapped(input logic [4:0] a);
    return (a >= 5'h10) && (a <= 5'h19) && (a != 5'h17);
  endfunction

  task automatic model_reset();
    ref_last_int = 1'b1;
    exp_h_rdata = '0; exp_i_rdata = '0; exp_h_err = 1'b0; exp_i_err = 1'b0;
  endtask

  task automatic model_init_replay();
    ref_mem[16] = 32'h0000_002A;
    ref_mem[17] = 32'h1234_5678;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hst_ack"}, hst_ack, 0);     chk({tag, "_int_ack"}, int_ack, 0);
    chk({tag, "_hst_rdata"}, hst_rdata, 0); chk({tag, "_int_rdata"}, int_rdata, 0);
    chk({tag, "_hst_err"}, hst_err, 0);     chk({tag, "_int_err"}, int_err, 0);
    chk({tag, "_reg_addr"}, reg_addr, 0);   chk({tag, "_reg_wdata"}, reg_wdata, 0);
    chk({tag, "_cs_n"}, reg_cs_n, 1);       chk({tag, "_wr_n"}, reg_wr_n, 1);
    chk({tag, "_init_done"}, init_done, 0); chk({tag, "_busy"}, busy, 0);
  endtask

  // Follow the init replay after reset release; int side must see no ack meanwhile
  task automatic check_init_replay(input string tag);
    @(posedge hclk); #1;
    chk({tag, "_c1_addr"}, reg_addr, 5'h10); chk({tag, "_c1_data"}, reg_wdata, 32'h2A);
    chk({tag, "_c1_cs_n"}, reg_cs_n, 0);     chk({tag, "_c1_wr_n"}, reg_wr_n, 0);
    chk({tag, "_c1_done"}, init_done, 0);    chk({tag, "_c1_busy"}, busy, 1);
    chk({tag, "_c1_iack"}, int_ack, 0);
    @(posedge hclk); #1;
    chk({tag, "_c2_addr"}, reg_addr, 5'h11); chk({tag, "_c2_data"}, reg_wdata, 32'h1234_5678);
    chk({tag, "_c2_cs_n"}, reg_cs_n, 0);     chk({tag, "_c2_done"}, init_done, 0);
    chk({tag, "_c2_iack"}, int_ack, 0);
    @(posedge hclk); #1;
    chk({tag, "_c3_cs_n"}, reg_cs_n, 1);     chk({tag, "_c3_wr_n"}, reg_wr_n, 1);
    chk({tag, "_c3_done"}, init_done, 1);    chk({tag, "_c3_iack"}, int_ack, 0);
    model_init_replay();
  endtask

  // One access from the IDLE cycle: predict grant and response, check 3 cycles
  task automatic serve(output bit g_int);
    logic [4:0]  a;
    logic [31:0] wd, rd;
    bit          w, er;
    g_int = (hst_req && int_req) ? (ref_last_int ? 1'b0 : 1'b1) : int_req;
    a  = g_int ? int_addr  : hst_addr;
    wd = g_int ? int_wdata : hst_wdata;
    w  = g_int ? int_wr    : hst_wr;
    er = !tb_mapped(a);
    rd = er ? 32'h0 : ref_mem[a];
    @(posedge hclk); #1;
    chk("issue_hst_ack", hst_ack, 0); chk("issue_int_ack", int_ack, 0);
    chk("issue_busy", busy, 1);       chk("issue_cs_n", reg_cs_n, 0);
    chk("issue_addr", reg_addr, a);   chk("issue_wr_n", reg_wr_n, !w);
    @(posedge hclk); #1;
    if (w && !er) ref_mem[a] = wd;
    if (g_int) begin exp_i_rdata = rd; exp_i_err = er; end
    else       begin exp_h_rdata = rd; exp_h_err = er; end
    ref_last_int = g_int;
    chk("ack_hst", hst_ack, !g_int);        chk("ack_int", int_ack, g_int);
    chk("hst_rdata", hst_rdata, exp_h_rdata); chk("hst_err", hst_err, exp_h_err);
    chk("int_rdata", int_rdata, exp_i_rdata); chk("int_err", int_err, exp_i_err);
    chk("ack_cs_n", reg_cs_n, 1);
    @(posedge hclk); #1;
    chk("post_hst_ack", hst_ack, 0); chk("post_int_ack", int_ack, 0);
    chk("post_busy", busy, 0);
  endtask

  task automatic host_access(input bit w, input logic [4:0] a, input logic [31:0] d);
    bit g;
    hst_req = 1'b1; hst_wr = w; hst_addr = a; hst_wdata = d;
    serve(g);
    chk("host_only_grant", g, 0);
    hst_req = 1'b0;
  endtask

  initial begin
    bit g, prev_g;
    int unsigned pat;
    model_reset();
    hresetn = 1'b0;
    hst_req = 0; hst_wr = 0; hst_addr = '0; hst_wdata = '0;
    int_req = 0; int_wr = 0; int_addr = '0; int_wdata = '0;
    f_hst_req = 0; f_hst_addr = 5'h12; f_hst_wdata = 32'h55;
    f_int_req = 0; f_int_addr = 5'h13; f_int_wdata = 32'h66;

    repeat (3) @(posedge hclk);
    #1;
    check_reset_outputs("rst");
    chk("fix_rst_done", f_init_done, 0);

    // Release with an internal read already pending during INIT
    hresetn = 1'b1;
    int_req = 1'b1; int_wr = 1'b0; int_addr = 5'h10;
    check_init_replay("init");
    chk("fix_init_done", f_init_done, 1);
    serve(g);
    chk("init_int_grant", g, 1);
    int_req = 1'b0;

    // Directed host accesses
    host_access(1'b1, 5'h12, 32'hDEAD_BEEF);
    host_access(1'b0, 5'h12, 32'h0);
    host_access(1'b0, 5'h11, 32'h0);
    host_access(1'b0, 5'h17, 32'h0);
    host_access(1'b1, 5'h17, 32'h0BAD_0BAD);
    host_access(1'b0, 5'h17, 32'h0);
    host_access(1'b0, 5'h10, 32'h0);

    // Both requesters held across 4 transfers: grants must alternate
    hst_req = 1; hst_wr = 0; hst_addr = 5'h12;
    int_req = 1; int_wr = 0; int_addr = 5'h11;
    for (int k = 0; k < 4; k++) begin
      serve(g);
      if (k > 0) chk("rr_alternate", g, !prev_g);
      prev_g = g;
    end
    hst_req = 0; int_req = 0;

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      pat = $urandom_range(1, 3);
      if (pat[0]) begin
        hst_req = 1; hst_wr = 1'($urandom_range(0, 1));
        hst_addr = 5'($urandom_range(14, 27)); hst_wdata = $urandom;
      end
      if (pat[1]) begin
        int_req = 1; int_wr = 1'($urandom_range(0, 1));
        int_addr = 5'($urandom_range(14, 27)); int_wdata = $urandom;
      end
      while (hst_req || int_req) begin
        serve(g);
        if (g) int_req = 0; else hst_req = 0;
      end
    end

    // Reset during ISSUE of a write to 0x13
    hst_req = 1; hst_wr = 1; hst_addr = 5'h13; hst_wdata = 32'hCAFE_F00D;
    @(posedge hclk); #1;
    chk("abort_cs_n", reg_cs_n, 0); chk("abort_addr", reg_addr, 5'h13);
    #2 hresetn = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("abort");
    hst_req = 0;
    @(posedge hclk); #1;
    chk("abort_no_ack", hst_ack, 0);
    hresetn = 1'b1;
    check_init_replay("replay");
    host_access(1'b0, 5'h13, 32'h0);
    host_access(1'b0, 5'h10, 32'h0);

    // Fixed-priority instance: host keeps winning while it holds req
    f_hst_req = 1; f_int_req = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge hclk); #1;
      chk("fix_cs_n", f_reg_cs_n, 0);    chk("fix_addr", f_reg_addr, 5'h12);
      chk("fix_wr_n", f_reg_wr_n, 1);    chk("fix_wdata", f_reg_wdata, 32'h55);
      chk("fix_busy", f_busy, 1);
      @(posedge hclk); #1;
      chk("fix_hst_ack", f_hst_ack, 1);  chk("fix_int_ack", f_int_ack, 0);
      chk("fix_hst_rdata", f_hst_rdata, F_BANK_DATA); chk("fix_hst_err", f_hst_err, 0);
      @(posedge hclk); #1;
      chk("fix_post_ack", f_hst_ack, 0);
    end
    f_hst_req = 0;
    @(posedge hclk); #1;
    chk("fix_int_addr", f_reg_addr, 5'h13);
    @(posedge hclk); #1;
    chk("fix_int_ack_late", f_int_ack, 1); chk("fix_int_rdata", f_int_rdata, F_BANK_DATA);
    chk("fix_int_err", f_int_err, 0);      chk("fix_hst_hold", f_hst_ack, 0);
    f_int_req = 0;
    repeat (2) @(posedge hclk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
